// File: rtl/order_responder.sv
// order_responder: frames a completed read order and its read-data bytes into
// a TX FIFO byte stream: header|RESP_FLAG, address, length[15:8], length[7:0],
// then length data bytes passed straight through from the read-data port.
// Optional build macro ORDER_RESPONDER_CHECKSUM_EN appends one byte holding
// the XOR of every byte sent in the frame.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | cmd_ready high, waiting for an order
// HEADER   | emitting echoed header with response flag
// ADDRESS  | emitting captured address
// LEN_HI   | emitting length[15:8]
// LEN_LO   | emitting length[7:0]; length 0 ends the payload here
// DATA     | passing read-data bytes through, counting down remaining bytes
// CKSUM    | (checksum build only) emitting running XOR of the frame
module order_responder #(
   parameter logic [7:0] RESP_FLAG = 8'h80
) (
   input  logic        clk_i,
   input  logic        res_n_i,
   input  logic        cmd_valid_i,
   output logic        cmd_ready_o,
   input  logic [7:0]  cmd_header_i,
   input  logic [7:0]  cmd_address_i,
   input  logic [15:0] cmd_length_i,
   input  logic [7:0]  rd_data_i,
   input  logic        rd_valid_i,
   output logic        rd_ready_o,
   output logic [7:0]  tx_data_o,
   output logic        tx_write_o,
   input  logic        tx_full_i,
   output logic        busy_o,
   output logic        frame_done_o
);

`ifdef ORDER_RESPONDER_CHECKSUM_EN
   typedef enum logic [2:0] {
      S_IDLE, S_HEADER, S_ADDRESS, S_LEN_HI, S_LEN_LO, S_DATA, S_CKSUM
   } state_t;
   // After the last payload byte the checksum still has to go out, so the
   // done pulse is deferred to the CKSUM write.
   localparam state_t END_STATE = S_CKSUM;
   localparam logic   END_DONE  = 1'b0;
`else
   typedef enum logic [2:0] {
      S_IDLE, S_HEADER, S_ADDRESS, S_LEN_HI, S_LEN_LO, S_DATA
   } state_t;
   localparam state_t END_STATE = S_IDLE;
   localparam logic   END_DONE  = 1'b1;
`endif

   state_t      state_q;
   logic [7:0]  hdr_q;
   logic [7:0]  addr_q;
   logic [15:0] len_q;
   logic [15:0] cnt_q;
   logic        frame_done_q;
`ifdef ORDER_RESPONDER_CHECKSUM_EN
   logic [7:0]  cksum_q;
   logic [7:0]  cksum_d;
`endif

   assign cmd_ready_o  = (state_q == S_IDLE);
   assign busy_o       = (state_q != S_IDLE);
   assign frame_done_o = frame_done_q;

   // Output byte mux and write strobe; data bytes pass through with no latency.
   always_comb begin
      tx_data_o  = 8'h00;
      tx_write_o = 1'b0;
      rd_ready_o = 1'b0;
      case (state_q)
         S_HEADER: begin
            tx_data_o  = hdr_q;
            tx_write_o = !tx_full_i;
         end
         S_ADDRESS: begin
            tx_data_o  = addr_q;
            tx_write_o = !tx_full_i;
         end
         S_LEN_HI: begin
            tx_data_o  = len_q[15:8];
            tx_write_o = !tx_full_i;
         end
         S_LEN_LO: begin
            tx_data_o  = len_q[7:0];
            tx_write_o = !tx_full_i;
         end
         S_DATA: begin
            tx_data_o  = rd_data_i;
            tx_write_o = rd_valid_i && !tx_full_i;
            rd_ready_o = rd_valid_i && !tx_full_i;
         end
`ifdef ORDER_RESPONDER_CHECKSUM_EN
         S_CKSUM: begin
            tx_data_o  = cksum_q;
            tx_write_o = !tx_full_i;
         end
`endif
         default: begin
            tx_data_o  = 8'h00;
            tx_write_o = 1'b0;
            rd_ready_o = 1'b0;
         end
      endcase
   end

`ifdef ORDER_RESPONDER_CHECKSUM_EN
   // Running XOR including the byte currently on the bus.
   assign cksum_d = cksum_q ^ tx_data_o;
`endif

   // Frame sequencing, order capture, remaining-byte counter and done pulse.
   always_ff @(posedge clk_i or negedge res_n_i) begin
      if (!res_n_i) begin
         state_q      <= S_IDLE;
         hdr_q        <= 8'h00;
         addr_q       <= 8'h00;
         len_q        <= 16'h0000;
         cnt_q        <= 16'h0000;
         frame_done_q <= 1'b0;
`ifdef ORDER_RESPONDER_CHECKSUM_EN
         cksum_q      <= 8'h00;
`endif
      end else begin
         frame_done_q <= 1'b0;
`ifdef ORDER_RESPONDER_CHECKSUM_EN
         if (tx_write_o) begin
            cksum_q <= cksum_d;
         end
`endif
         case (state_q)
            S_IDLE: begin
               if (cmd_valid_i) begin
                  hdr_q   <= cmd_header_i | RESP_FLAG;
                  addr_q  <= cmd_address_i;
                  len_q   <= cmd_length_i;
                  cnt_q   <= cmd_length_i;
`ifdef ORDER_RESPONDER_CHECKSUM_EN
                  cksum_q <= 8'h00;
`endif
                  state_q <= S_HEADER;
               end
            end
            S_HEADER: begin
               if (tx_write_o) state_q <= S_ADDRESS;
            end
            S_ADDRESS: begin
               if (tx_write_o) state_q <= S_LEN_HI;
            end
            S_LEN_HI: begin
               if (tx_write_o) state_q <= S_LEN_LO;
            end
            S_LEN_LO: begin
               if (tx_write_o) begin
                  if (cnt_q == 16'd0) begin
                     state_q      <= END_STATE;
                     frame_done_q <= END_DONE;
                  end else begin
                     state_q <= S_DATA;
                  end
               end
            end
            S_DATA: begin
               // cnt_q is at least 1 here, so the decrement cannot wrap.
               if (tx_write_o) begin
                  cnt_q <= cnt_q - 16'd1;
                  if (cnt_q == 16'd1) begin
                     state_q      <= END_STATE;
                     frame_done_q <= END_DONE;
                  end
               end
            end
`ifdef ORDER_RESPONDER_CHECKSUM_EN
            S_CKSUM: begin
               if (tx_write_o) begin
                  state_q      <= S_IDLE;
                  frame_done_q <= 1'b1;
               end
            end
`endif
            default: state_q <= S_IDLE;
         endcase
      end
   end

endmodule
